bsg_hypotenuse_feeder: RTL

// - Sits directly upstream of bsg_hypotenuse and drives its x_i/y_i inputs.
// - Accepts signed Cartesian samples on a valid/ready handshake and converts them to unsigned magnitudes.
// - Tracks valid samples alongside the fixed-latency, flow-control-free hypotenuse pipeline.
// - Captures hyp results into a result FIFO and presents them on a valid/yumi interface.
// - Credit-based admission guarantees that no result is ever dropped.

---
 rtl/bsg_hypotenuse_feeder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bsg_hypotenuse_feeder.sv
// bsg_hypotenuse_feeder: front end and result buffer for bsg_hypotenuse.
// Converts signed samples to magnitudes, tracks them through the fixed-latency
// hypotenuse pipeline, and buffers the results behind credit-based admission.
// Optional tag sideband is enabled with `define BSG_HYPOTENUSE_FEEDER_TAG_EN.
module bsg_hypotenuse_feeder #(
  parameter int width_p   = 12,
  parameter int latency_p = 16,
  parameter int els_p     = 18
`ifdef BSG_HYPOTENUSE_FEEDER_TAG_EN
  , parameter int tag_width_p = 4
`endif
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] x_i,
  input  logic [width_p-1:0] y_i,
  output logic               ready_o,
  output logic [width_p-1:0] hyp_x_o,
  output logic [width_p-1:0] hyp_y_o,
  input  logic [width_p:0]   hyp_i,
  output logic               v_o,
  output logic [width_p:0]   data_o,
  input  logic               yumi_i
`ifdef BSG_HYPOTENUSE_FEEDER_TAG_EN
  , input  logic [tag_width_p-1:0] tag_i
  , output logic [tag_width_p-1:0] tag_o
`endif
);

  localparam int PtrW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CntW = $clog2(els_p + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(els_p - 1);
  localparam logic [CntW-1:0] Full    = CntW'(els_p);

  logic [CntW-1:0]    r_credits;
  logic [width_p-1:0] r_hypX;
  logic [width_p-1:0] r_hypY;
  logic [latency_p:0] r_validLine;
  logic [width_p:0]   r_mem [els_p];
  logic [PtrW-1:0]    r_wrPtr;
  logic [PtrW-1:0]    r_rdPtr;
  logic [CntW-1:0]    r_count;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [width_p-1:0] w_absX;
  logic [width_p-1:0] w_absY;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign ready_o  = (r_credits != '0);
  assign v_o      = (r_count != '0);
  assign w_accept = v_i & ready_o;
  assign w_pop    = yumi_i & v_o;
  assign w_push   = r_validLine[latency_p];
  assign w_absX   = x_i[width_p-1] ? (-x_i) : x_i;
  assign w_absY   = y_i[width_p-1] ? (-y_i) : y_i;
  assign hyp_x_o  = r_hypX;
  assign hyp_y_o  = r_hypY;
  assign data_o   = v_o ? r_mem[r_rdPtr] : '0;

  // Credits track free FIFO slots minus results still inside the hypotenuse pipeline.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_credits <= Full;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits - CntW'(1);
        2'b01:   r_credits <= r_credits + CntW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Magnitudes are latched on accept and held otherwise; the most negative input maps exactly.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_hypX <= '0;
      r_hypY <= '0;
    end else if (w_accept) begin
      r_hypX <= w_absX;
      r_hypY <= w_absY;
    end
  end

  // Valid bits walk beside the hypotenuse pipeline; the last stage qualifies hyp_i.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_validLine <= '0;
    end else begin
      r_validLine <= {r_validLine[latency_p-1:0], w_accept};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result storage needs no reset; data_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= hyp_i;
    end
  end

`ifdef BSG_HYPOTENUSE_FEEDER_TAG_EN
  logic [tag_width_p-1:0] r_tagLine [latency_p+1];
  logic [tag_width_p-1:0] r_tagMem  [els_p];

  assign tag_o = v_o ? r_tagMem[r_rdPtr] : '0;

  // Tags ride a delay line parallel to the valid bits; validity comes from r_validLine.
  always_ff @(posedge clk_i) begin
    r_tagLine[0] <= tag_i;
    for (int i = 1; i <= latency_p; i++) begin
      r_tagLine[i] <= r_tagLine[i-1];
    end
  end

  // Each tag is stored in the slot of the result it belongs to.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tagMem[r_wrPtr] <= r_tagLine[latency_p];
    end
  end
`endif

  // Popping an empty FIFO or pushing into a full one indicates a broken upstream contract.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o));
      assert (!(w_push && (r_count == Full) && !w_pop));
    end
  end

endmodule
